// File: rtl/hermes_switch_control.sv
// rtl/hermes_switch_control.sv - Hermes router switch control: round-robin header arbitration, XY/YX routing, connection table
//
// Arbitrates header requests from all input ports, computes each packet's
// output port and records input->output connections until the packet is
// released. Port indices: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4..NPORT-1.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   req_i       per input: header flit waiting to be routed
//   header_i    per input: header flit ({X,Y} target in the low ADDR_WIDTH bits)
//   release_i   per input: packet finished, drop its connection (pulse)
//   ack_h_o     per input: one-cycle pulse, header routed and connection made
//   free_o      per output: output not allocated
//   out_sel_o   per output: input driving that output (crossbar mux select)
//   in_sel_o    per input: output allocated to that input
//   in_valid_o  per input: input holds a connection
module hermes_switch_control #(
    parameter int                    NLOCAL     = 1,
    parameter int                    FLIT_SIZE  = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] ROUTER_ADDR = 8'h00,
    parameter bit                    YX_ROUTING = 1'b0,
    localparam int                   NPORT      = 4 + NLOCAL,
    localparam int                   SELW       = $clog2(NPORT)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NPORT-1:0]                 req_i,
    input  logic [NPORT-1:0][FLIT_SIZE-1:0]  header_i,
    input  logic [NPORT-1:0]                 release_i,
    output logic [NPORT-1:0]                 ack_h_o,
    output logic [NPORT-1:0]                 free_o,
    output logic [NPORT-1:0][SELW-1:0]       out_sel_o,
    output logic [NPORT-1:0][SELW-1:0]       in_sel_o,
    output logic [NPORT-1:0]                 in_valid_o
);

    localparam int HALF  = ADDR_WIDTH / 2;
    localparam int LSELW = (NLOCAL > 1) ? $clog2(NLOCAL) : 1;

    localparam logic [SELW-1:0] P_EAST  = SELW'(0);
    localparam logic [SELW-1:0] P_WEST  = SELW'(1);
    localparam logic [SELW-1:0] P_NORTH = SELW'(2);
    localparam logic [SELW-1:0] P_SOUTH = SELW'(3);
    localparam logic [SELW-1:0] P_LOCAL = SELW'(4);

    localparam logic [HALF-1:0] LX = ROUTER_ADDR[ADDR_WIDTH-1:HALF];
    localparam logic [HALF-1:0] LY = ROUTER_ADDR[HALF-1:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ROUTE,
        S_GRANT
    } state_t;

    state_t                    state_q, state_d;
    logic [SELW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0]           cur_in_q, cur_in_d;
    logic [SELW-1:0]           dest_q, dest_d;
    logic [NPORT-1:0]          ack_q, ack_d;
    logic [NPORT-1:0]          free_q, free_d;
    logic [NPORT-1:0][SELW-1:0] out_sel_q, out_sel_d;
    logic [NPORT-1:0][SELW-1:0] in_sel_q, in_sel_d;
    logic [NPORT-1:0]          in_valid_q, in_valid_d;

    // Inputs already holding a connection cannot start another packet.
    logic [NPORT-1:0] eligible;
    logic             pick_found;
    logic [SELW-1:0]  pick_idx;

    assign eligible = req_i & ~in_valid_q;

    // Circular search starting just after the last served input.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        for (int k = 1; k <= NPORT; k++) begin
            if (!pick_found && eligible[(int'(rr_ptr_q) + k) % NPORT]) begin
                pick_found = 1'b1;
                pick_idx   = SELW'((int'(rr_ptr_q) + k) % NPORT);
            end
        end
    end

    // Header decode for the input currently being routed.
    logic [FLIT_SIZE-1:0] cur_hdr;
    logic [HALF-1:0]      tx, ty;
    logic [SELW-1:0]      local_port;
    logic [SELW-1:0]      route_dest;
    logic                 unused_hdr;

    assign cur_hdr    = header_i[cur_in_q];
    assign tx         = cur_hdr[ADDR_WIDTH-1:HALF];
    assign ty         = cur_hdr[HALF-1:0];
    assign unused_hdr = ^cur_hdr;

    if (NLOCAL > 1) begin : g_multi_local
        logic [LSELW-1:0] lsel;
        assign lsel       = cur_hdr[ADDR_WIDTH +: LSELW];
        // Local selectors beyond the implemented ports fall back to the first local port.
        assign local_port = (int'(lsel) + 4 < NPORT) ? SELW'(int'(lsel) + 4) : P_LOCAL;
    end else begin : g_single_local
        assign local_port = P_LOCAL;
    end

    always_comb begin
        route_dest = local_port;
        if (YX_ROUTING) begin
            if (ty > LY)      route_dest = P_NORTH;
            else if (ty < LY) route_dest = P_SOUTH;
            else if (tx > LX) route_dest = P_EAST;
            else if (tx < LX) route_dest = P_WEST;
        end else begin
            if (tx > LX)      route_dest = P_EAST;
            else if (tx < LX) route_dest = P_WEST;
            else if (ty > LY) route_dest = P_NORTH;
            else if (ty < LY) route_dest = P_SOUTH;
        end
    end

    // An output being released this very cycle is not handed out yet, so a
    // release and a grant never collide on the same table entry.
    logic [SELW-1:0] dest_owner;
    logic            owner_releasing;
    logic            grant_ok;

    assign dest_owner      = out_sel_q[route_dest];
    assign owner_releasing = release_i[dest_owner] && in_valid_q[dest_owner]
                             && (in_sel_q[dest_owner] == route_dest);
    assign grant_ok        = free_q[route_dest] && !owner_releasing;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_in_d   = cur_in_q;
        dest_d     = dest_q;
        ack_d      = '0;
        free_d     = free_q;
        out_sel_d  = out_sel_q;
        in_sel_d   = in_sel_q;
        in_valid_d = in_valid_q;

        // Releases apply in every state; the grant below may add to them.
        for (int p = 0; p < NPORT; p++) begin
            if (release_i[p] && in_valid_q[p]) begin
                free_d[in_sel_q[p]] = 1'b1;
                in_valid_d[p]       = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|eligible) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (pick_found) begin
                    cur_in_d = pick_idx;
                    rr_ptr_d = pick_idx;
                    state_d  = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUTE: begin
                dest_d  = route_dest;
                state_d = grant_ok ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                ack_d[cur_in_q]      = 1'b1;
                free_d[dest_q]       = 1'b0;
                out_sel_d[dest_q]    = cur_in_q;
                in_sel_d[cur_in_q]   = dest_q;
                in_valid_d[cur_in_q] = 1'b1;
                state_d              = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= SELW'(NPORT - 1);
            cur_in_q   <= '0;
            dest_q     <= '0;
            ack_q      <= '0;
            free_q     <= '1;
            out_sel_q  <= '0;
            in_sel_q   <= '0;
            in_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_in_q   <= cur_in_d;
            dest_q     <= dest_d;
            ack_q      <= ack_d;
            free_q     <= free_d;
            out_sel_q  <= out_sel_d;
            in_sel_q   <= in_sel_d;
            in_valid_q <= in_valid_d;
        end
    end

    assign ack_h_o    = ack_q;
    assign free_o     = free_q;
    assign out_sel_o  = out_sel_q;
    assign in_sel_o   = in_sel_q;
    assign in_valid_o = in_valid_q;

endmodule

// File: tb/tb_hermes_switch_control.sv
// tb/tb_hermes_switch_control.sv - self-checking bench for hermes_switch_control
module tb_hermes_switch_control;

    localparam int NL = 2;
    localparam int NP = 4 + NL;
    localparam int SW = $clog2(NP);

    logic                    clk;
    logic                    rst;
    logic [NP-1:0]           req;
    logic [NP-1:0][31:0]     hdr;
    logic [NP-1:0]           rel;
    logic                    yx_en;
    logic [NP-1:0]           req_y, rel_y;

    logic [NP-1:0]           ack_m, free_m, valid_m;
    logic [NP-1:0][SW-1:0]   out_sel_m, in_sel_m;
    logic [NP-1:0]           ack_y, free_y, valid_y;
    logic [NP-1:0][SW-1:0]   out_sel_y, in_sel_y;

    assign req_y = yx_en ? req : '0;
    assign rel_y = yx_en ? rel : '0;

    hermes_switch_control #(
        .NLOCAL(NL), .FLIT_SIZE(32), .ADDR_WIDTH(8), .ROUTER_ADDR(8'h11), .YX_ROUTING(1'b0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .header_i(hdr), .release_i(rel),
        .ack_h_o(ack_m), .free_o(free_m), .out_sel_o(out_sel_m),
        .in_sel_o(in_sel_m), .in_valid_o(valid_m)
    );

    hermes_switch_control #(
        .NLOCAL(NL), .FLIT_SIZE(32), .ADDR_WIDTH(8), .ROUTER_ADDR(8'h11), .YX_ROUTING(1'b1)
    ) dut_yx (
        .clk_i(clk), .rst_i(rst), .req_i(req_y), .header_i(hdr), .release_i(rel_y),
        .ack_h_o(ack_y), .free_o(free_y), .out_sel_o(out_sel_y),
        .in_sel_o(in_sel_y), .in_valid_o(valid_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: owner[o] is the input holding output o, or -1.
    int owner [NP];

    function automatic int model_dest(input logic [31:0] h, input bit yx);
        int dx, dy, loc;
        dx  = int'(h[7:4]) - 1;
        dy  = int'(h[3:0]) - 1;
        loc = 4 + int'(h[8]);
        if (loc >= NP) loc = 4;
        if (yx) begin
            if (dy > 0) return 2;
            if (dy < 0) return 3;
            if (dx > 0) return 0;
            if (dx < 0) return 1;
        end else begin
            if (dx > 0) return 0;
            if (dx < 0) return 1;
            if (dy > 0) return 2;
            if (dy < 0) return 3;
        end
        return loc;
    endfunction

    function automatic logic [31:0] exp_free();
        logic [31:0] v = '0;
        for (int o = 0; o < NP; o++) if (owner[o] < 0) v[o] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] exp_valid();
        logic [31:0] v = '0;
        for (int o = 0; o < NP; o++) if (owner[o] >= 0) v[owner[o]] = 1'b1;
        return v;
    endfunction

    function automatic int held_by(input int p);
        for (int o = 0; o < NP; o++) if (owner[o] == p) return o;
        return -1;
    endfunction

    function automatic void model_release(input int p);
        for (int o = 0; o < NP; o++) if (owner[o] == p) owner[o] = -1;
    endfunction

    function automatic void model_reset();
        for (int o = 0; o < NP; o++) owner[o] = -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int p, input int bound, output int n);
        n = bound + 1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (ack_m[p]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    logic [31:0] dir_hdr [4];
    int          dir_port [4];
    logic [31:0] h;
    int          p, q, d, dy, n, seen;
    int          t [3];

    initial begin
        req = '0; hdr = '0; rel = '0; yx_en = 1'b1; rst = 1'b0;
        model_reset();
        dir_hdr  = '{32'h31, 32'h33, 32'h11, 32'h111};
        dir_port = '{4, 4, 0, 2};

        do_reset();
        chk("reset_ack", 32'(ack_m), 32'h0);
        chk("reset_free", 32'(free_m), 32'h3f);
        chk("reset_valid", 32'(valid_m), 32'h0);
        chk("reset_out_sel", 32'(out_sel_m), 32'h0);
        chk("reset_in_sel", 32'(in_sel_m), 32'h0);
        chk("reset_yx_free", 32'(free_y), 32'h3f);
        chk("reset_yx_valid", 32'(valid_y), 32'h0);
        chk("reset_yx_out_sel", 32'(out_sel_y), 32'h0);

        // Routing on both orders: single requester, all outputs free each time.
        for (int it = 0; it < 12; it++) begin
            if (it < 4) begin
                p = dir_port[it];
                h = dir_hdr[it];
            end else begin
                p = int'($urandom_range(0, NP - 1));
                h = $urandom;
                h[7:4] = 4'($urandom_range(0, 3));
                h[3:0] = 4'($urandom_range(0, 3));
            end
            d  = model_dest(h, 1'b0);
            dy = model_dest(h, 1'b1);
            hdr[p] = h;
            req[p] = 1'b1;
            wait_ack(p, 10, n);
            chk($sformatf("latency_in%0d_h%0h", p, h), 32'(n), 32'd4);
            chk("yx_ack", 32'(ack_y[p]), 32'd1);
            chk($sformatf("xy_dest_h%0h", h), 32'(in_sel_m[p]), 32'(d));
            chk($sformatf("yx_dest_h%0h", h), 32'(in_sel_y[p]), 32'(dy));
            chk("xy_out_sel", 32'(out_sel_m[d]), 32'(p));
            chk("xy_free", 32'(free_m), 32'(6'h3f & ~(6'd1 << d)));
            req[p] = 1'b0;
            tick();
            chk("ack_one_cycle", 32'(ack_m), 32'h0);
            rel[p] = 1'b1;
            tick();
            rel[p] = 1'b0;
            chk("release_free", 32'(free_m), 32'h3f);
            chk("release_valid", 32'(valid_m), 32'h0);
        end
        yx_en = 1'b0;

        // Fairness: three inputs at once to disjoint outputs.
        do_reset();
        hdr[0] = 32'h01; hdr[1] = 32'h31; hdr[2] = 32'h10;
        req[2:0] = 3'b111;
        t = '{0, 0, 0};
        for (int i = 1; i <= 16; i++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
                if (ack_m[j] && t[j] == 0) begin
                    t[j]   = i;
                    req[j] = 1'b0;
                end
            end
        end
        for (int j = 0; j < 3; j++) chk($sformatf("fair_time_in%0d", j), 32'(t[j]), 32'(4 * (j + 1)));
        owner[1] = 0; owner[0] = 1; owner[3] = 2;
        chk("fair_free", 32'(free_m), exp_free());
        chk("fair_valid", 32'(valid_m), exp_valid());

        // Reset while three connections are held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midreset_free", 32'(free_m), 32'h3f);
        chk("midreset_valid", 32'(valid_m), 32'h0);
        chk("midreset_ack", 32'(ack_m), 32'h0);

        // Contention: WEST then SOUTH both toward EAST.
        hdr[1] = 32'h31; req[1] = 1'b1;
        wait_ack(1, 10, n);
        chk("cont_first_latency", 32'(n), 32'd4);
        req[1] = 1'b0;
        owner[0] = 1;
        hdr[3] = 32'h31; req[3] = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (|ack_m) seen = 1;
        end
        chk("cont_blocked", 32'(seen), 32'd0);
        rel[1] = 1'b1;
        n = 17;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1) rel[1] = 1'b0;
            if (ack_m[3]) begin n = i; break; end
        end
        chk("cont_unblock_within8", 32'(n <= 8), 32'd1);
        req[3] = 1'b0;
        owner[0] = 3;
        chk("cont_free", 32'(free_m), exp_free());
        chk("cont_out_sel", 32'(out_sel_m[0]), 32'd3);
        chk("cont_valid", 32'(valid_m), exp_valid());

        // Release of another output during the GRANT cycle.
        hdr[4] = 32'h13; req[4] = 1'b1;
        tick(); tick(); tick();
        rel[3] = 1'b1;
        tick();
        rel[3] = 1'b0; req[4] = 1'b0;
        model_release(3);
        owner[2] = 4;
        chk("grant_rel_ack", 32'(ack_m), 32'h10);
        chk("grant_rel_free", 32'(free_m), exp_free());
        chk("grant_rel_valid", 32'(valid_m), exp_valid());

        // Release on an input without a connection changes nothing.
        rel[0] = 1'b1;
        tick();
        rel[0] = 1'b0;
        tick();
        chk("idle_rel_free", 32'(free_m), exp_free());
        chk("idle_rel_valid", 32'(valid_m), exp_valid());

        // Random traffic against the connection-table model.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                q = int'($urandom_range(0, NP - 1));
                rel[q] = 1'b1;
                tick();
                rel[q] = 1'b0;
                model_release(q);
            end
            p = -1;
            for (int tries = 0; tries < 40 && p < 0; tries++) begin
                q = int'($urandom_range(0, NP - 1));
                if (held_by(q) < 0) p = q;
            end
            if (p >= 0) begin
                h = $urandom;
                h[7:4] = 4'($urandom_range(0, 3));
                h[3:0] = 4'($urandom_range(0, 3));
                d = model_dest(h, 1'b0);
                hdr[p] = h;
                req[p] = 1'b1;
                if (owner[d] < 0) begin
                    wait_ack(p, 10, n);
                    chk($sformatf("rnd_latency_in%0d", p), 32'(n), 32'd4);
                end else begin
                    seen = 0;
                    for (int i = 0; i < 12; i++) begin
                        tick();
                        if (|ack_m) seen = 1;
                    end
                    chk($sformatf("rnd_blocked_in%0d_out%0d", p, d), 32'(seen), 32'd0);
                    q = owner[d];
                    rel[q] = 1'b1;
                    n = 17;
                    for (int i = 1; i <= 16; i++) begin
                        tick();
                        if (i == 1) rel[q] = 1'b0;
                        if (ack_m[p]) begin n = i; break; end
                    end
                    chk("rnd_unblock_within8", 32'(n <= 8), 32'd1);
                    model_release(q);
                end
                owner[d] = p;
                req[p] = 1'b0;
                chk("rnd_in_sel", 32'(in_sel_m[p]), 32'(d));
                chk("rnd_out_sel", 32'(out_sel_m[d]), 32'(p));
                tick();
                chk("rnd_ack_one_cycle", 32'(ack_m), 32'h0);
                chk("rnd_free", 32'(free_m), exp_free());
                chk("rnd_valid", 32'(valid_m), exp_valid());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
